// File: rtl/lane_rr_arbiter_if.sv
// Bus between the lane round-robin arbiter and its requesters / lane bank.
// Carries the request vector, beat data, grant and the output beat handshake.
interface lane_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 4
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    grant;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic [IW-1:0]      out_src;
    logic               out_ready;
    logic               busy;

    modport master (
        output req,
        output req_data,
        output out_ready,
        input  grant,
        input  out_valid,
        input  out_data,
        input  out_src,
        input  busy
    );

    modport slave (
        input  req,
        input  req_data,
        input  out_ready,
        output grant,
        output out_valid,
        output out_data,
        output out_src,
        output busy
    );
endinterface

// File: rtl/lane_rr_arbiter.sv
// Round-robin arbiter sharing one registered 4-lane output stage between
// requesters, with valid/ready backpressure and a per-tenure burst limit.
module lane_rr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 4,
    parameter int MAX_BURST = 8
) (
    input logic              clk,
    input logic              rst,
    lane_rr_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   hold_q;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] grant_q;
    logic            out_valid_q;
    logic [DW-1:0]   out_data_q;
    logic [IW-1:0]   out_src_q;

    logic            any_req;
    logic            hold_req;
    logic [DW-1:0]   hold_data;
    logic            out_free;
    logic            xfer;
    logic            last;
    logic            rel;
    logic [IW-1:0]   nxt_ptr;
    logic [IW-1:0]   arb_ptr;
    logic [IW-1:0]   win;
    logic            found;

    // Holder handshake: transfer, burst-limit hit and release detection.
    always_comb begin
        any_req   = |bus.req;
        hold_req  = bus.req[hold_q];
        hold_data = bus.req_data[int'(hold_q)*DW +: DW];
        out_free  = !out_valid_q || bus.out_ready;
        xfer      = (state_q == GRANT) && hold_req && out_free;
        last      = xfer && (cnt_q == CW'(MAX_BURST - 1));
        rel       = (state_q == GRANT) && (!hold_req || last);
        nxt_ptr   = (hold_q == IW'(NREQ - 1)) ? '0 : hold_q + 1'b1;
        arb_ptr   = rel ? nxt_ptr : ptr_q;
    end

    // Circular priority search starting at the (possibly just advanced) pointer.
    always_comb begin
        win   = arb_ptr;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req[(int'(arb_ptr) + i) % NREQ]) begin
                found = 1'b1;
                win   = IW'((int'(arb_ptr) + i) % NREQ);
            end
        end
    end

    // Grant FSM plus the single output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= hold_data;
                out_src_q   <= hold_q;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= GRANT;
                        hold_q  <= win;
                        grant_q <= ONE << win;
                        cnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        ptr_q <= nxt_ptr;
                        cnt_q <= '0;
                        if (any_req) begin
                            hold_q  <= win;
                            grant_q <= ONE << win;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                        end
                    end else if (xfer) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.busy      = |grant_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule

// File: doc/lane_rr_arbiter.md
Name: lane_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 4-lane buffered datapath among several requesters. It feeds the lane bank's A[3:0] inputs.
- Grants the path to one requester at a time.
- Moves that requester's beats through a single registered output stage with valid/ready backpressure.
- Bounds each tenure with a burst limit so no requester can starve the others.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 4, beat width in bits; matches the lane bank width
MAX_BURST, 8, maximum beats per grant tenure (1..255)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
req  input  NREQ  per-requester request; also acts as that requester's beat-valid
req_data  input  NREQ*DW  per-requester beat data; requester i occupies bits [i*DW +: DW]
grant  output  NREQ  one-hot grant (all-zero when idle); registered
out_valid  output  1  output beat valid
out_data  output  DW  output beat data, driven to the lane bank
out_src  output  clog2(NREQ)  index of the requester that produced out_data
out_ready  input  1  downstream accepts the beat when out_valid & out_ready
busy  output  1  high while any grant is held

Behaviour:
- Reset (rst=1 at an edge):
  - grant=0, out_valid=0, out_data=0, out_src=0, busy=0.
  - Round-robin pointer ptr=0, beat counter cnt=0, state=IDLE.
  - Reset overrides all other inputs that cycle.
  - An in-flight output beat is discarded; it is not required to be delivered.
- States: IDLE, GRANT.
- IDLE:
  - If any req bit is high at edge N, grant becomes one-hot at edge N+1 (1-cycle arbitration latency).
  - Winner = first set req bit searching ptr, ptr+1, ... modulo NREQ.
  - state becomes GRANT, busy=1, cnt=0.
  - If no req is high, remain in IDLE with grant=0.
- GRANT (holder h):
  - Outreg is free when out_valid=0 or out_ready=1.
  - A beat transfers when req[h]=1 and outreg is free.
  - On transfer: out_data <= req_data[h], out_src <= h, out_valid <= 1, cnt <= cnt+1.
  - No transfer but out_valid & out_ready: out_valid <= 0; out_data and out_src hold their values.
  - A stalled beat (out_valid=1, out_ready=0) holds out_data, out_src and out_valid. No new beat is taken, and the requester must keep req high.
- Release:
  - Triggered when req[h]=0 at an edge, or when a transfer makes cnt reach MAX_BURST.
  - On release: ptr <= (h+1) mod NREQ.
  - The next grant is computed in the same cycle from the current req with the new ptr, so there is no idle bubble when others are requesting.
  - If the new winner is h again (sole requester), h is re-granted with cnt=0.
  - If no req remains: grant=0, busy=0, state=IDLE.
- Output stage: exactly one register between requester and out_data.
  - A beat's latency is 1 cycle from its transfer edge to out_valid.
  - The output beat is independent of grant changes; a beat already in outreg completes after release.
- Requests from non-holders are ignored for data purposes; their req_data is never sampled.
- grant is always zero or one-hot. busy == |grant.
- cnt width is clog2(MAX_BURST+1) and never wraps. When cnt reaches MAX_BURST, the grant is forced to release on that same transfer edge.

Test Plan:
- Reset mid-burst: req=4'b0001, 3 beats transferred, then rst=1 for 1 cycle -> grant=0, out_valid=0, out_data=0, busy=0 next cycle; with req still 1 after rst drops, grant=4'b0001 one cycle later.
- Single requester, out_ready=1: req[2]=1 with data 4'hA,4'h5,4'hC -> grant=4'b0100 at cycle 1; out_data A,5,C on cycles 2,3,4, each with out_src=2.
- Burst limit, MAX_BURST=8: req=4'b0011 held, out_ready=1 -> r0 gets 8 beats then grant switches to 4'b0010 on the next edge with no gap; r1 gets 8 beats, then r0 again.
- Round-robin fairness: all four req held, MAX_BURST=1 -> grant sequence 0001,0010,0100,1000,0001.
- Backpressure: out_ready=0 for 3 cycles after the first beat 4'h3 -> out_data stays 3 with out_valid=1 and no further transfers; cnt stays 1; transfers resume the cycle after out_ready=1.
- Voluntary release: holder r1 drops req after 2 beats while r3 requests -> grant goes to 4'b1000 on the next edge; ptr=2; the last r1 beat is still delivered with out_src=1.
